mem_access_ctrl: RTL and testbench

Initiator-side controller for the team's 32x4 synchronous RAM (registered read, 1-cycle latency, independent read/write address ports). Accepts single-outstanding LOAD / STORE / FILL requests over a valid/ready handshake. Sequences the RAM read/write strobes and addresses, and returns one response per request over a second valid/ready handshake. Sits between the processor datapath / load-store logic and the RAM.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_addr_gen.sv | 35 +++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access controller: op codes, FSM state codes, default widths.
package mem_access_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_FILL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_CAP  = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_FILL = 3'd4;
  localparam state_t ST_RESP = 3'd5;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the load-store logic (master) and the controller (slave).
interface mem_access_ctrl_if
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_data, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mem_access_addr_gen.sv
// Address register with wrap-around increment plus the FILL word down-counter.
module mem_access_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] count_reg;

  // The increment overflows naturally, giving the modulo-depth wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      addr_reg  <= load_addr;
      count_reg <= load_len;
    end else if (step) begin
      addr_reg  <= addr_reg + ADDR_W'(1);
      count_reg <= count_reg - ADDR_W'(1);
    end
  end

  assign addr = addr_reg;
  assign last = (count_reg == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding LOAD/STORE/FILL controller for the registered-read RAM.
// Optional STORE read-back verification: define MEM_ACCESS_CTRL_VERIFY_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_data_to_write,
  input  logic [DATA_W-1:0] mem_data_read
);

  state_t            state_reg;
  op_e               op_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;

  logic              ready;
  logic              accept;
  logic              ag_step;
  logic              ag_last;
  logic [ADDR_W-1:0] ag_addr;

  assign ready   = (state_reg == ST_IDLE);
  assign accept  = bus.req_valid && ready;
  assign ag_step = (state_reg == ST_FILL) && !ag_last;

  mem_access_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (ag_step),
    .load_addr (bus.req_addr),
    .load_len  (bus.req_len),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_LOAD;
      data_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg       <= op_e'(bus.req_op);
            data_reg     <= bus.req_data;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            case (op_e'(bus.req_op))
              OP_LOAD: begin
                state_reg    <= ST_RD;
                mem_read_reg <= 1'b1;
              end
              OP_STORE: begin
                state_reg     <= ST_WR;
                mem_write_reg <= 1'b1;
              end
              OP_FILL: begin
                state_reg     <= ST_FILL;
                mem_write_reg <= 1'b1;
              end
              default: begin
                state_reg   <= ST_RESP;
                rsp_err_reg <= 1'b1;
              end
            endcase
          end
        end
        ST_RD: begin
          mem_read_reg <= 1'b0;
          state_reg    <= ST_CAP;
        end
        ST_CAP: begin
          // Only a LOAD returns read data; a STORE read-back only flags a mismatch.
          if (op_reg == OP_LOAD) begin
            rsp_data_reg <= mem_data_read;
          end else begin
            rsp_err_reg <= (mem_data_read != data_reg);
          end
          state_reg <= ST_RESP;
        end
        ST_WR: begin
          mem_write_reg <= 1'b0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
          mem_read_reg  <= 1'b1;
          state_reg     <= ST_RD;
`else
          state_reg     <= ST_RESP;
`endif
        end
        ST_FILL: begin
          if (ag_last) begin
            mem_write_reg <= 1'b0;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // rsp_valid rises one cycle after entering RESP and holds until taken.
          if (!rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_data      = rsp_data_reg;
  assign bus.rsp_err       = rsp_err_reg;
  assign mem_read          = mem_read_reg;
  assign mem_write         = mem_write_reg;
  assign mem_read_address  = ag_addr;
  assign mem_write_address = ag_addr;
  assign mem_data_to_write = data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a bench-side RAM and an array-based reference memory.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  localparam int  STORE_LAT = 4;
  localparam bit  VERIFY    = 1'b1;
`else
  localparam int  STORE_LAT = 2;
  localparam bit  VERIFY    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_read, mem_write;
  logic [4:0] mem_read_address, mem_write_address;
  logic [3:0] mem_data_to_write, mem_data_read;

  mem_access_ctrl_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_to_write (mem_data_to_write),
    .mem_data_read     (mem_data_read)
  );

  always #5 clk = ~clk;

  // Bench RAM: registered read, independent ports; corrupt forces the read data to zero.
  logic [3:0] ram [32] = '{default: 4'h0};
  logic [3:0] rd_q = 4'h0;
  logic       corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_data_to_write;
    if (mem_read)  rd_q <= ram[mem_read_address];
  end
  assign mem_data_read = corrupt ? 4'h0 : rd_q;

  logic [3:0] model [32] = '{default: 4'h0};
  logic [4:0] wr_log [$];
  logic [3:0] wd_log [$];
  logic [4:0] rd_log [$];
  int         overlap = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_log.push_back(mem_write_address);
      wd_log.push_back(mem_data_to_write);
    end
    if (mem_read) rd_log.push_back(mem_read_address);
    if (mem_read && mem_write) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called in the low clock phase; returns 1ns after the accepting edge with fields scrambled.
  task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [3:0] data,
                      input logic [4:0] len);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_len   = len;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = 5'($urandom);
    bus.req_data  = 4'($urandom);
    bus.req_len   = 5'($urandom);
  endtask

  task automatic get_rsp(input int exp_lat, input logic [3:0] exp_data, input logic exp_err,
                         input int stall, output int lat, output logic [3:0] got_data,
                         output logic got_err);
    int n;
    logic [4:0] held;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid || n > 80) break;
      n++;
    end
    lat = n;
    got_data = bus.rsp_data;
    got_err  = bus.rsp_err;
    chk("rsp_latency", n, exp_lat);
    if (!bus.rsp_valid) return;
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_err", bus.rsp_err, exp_err);
    held = {bus.rsp_data, bus.rsp_err};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_payload", {bus.rsp_data, bus.rsp_err}, held);
      chk("busy_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("idle_req_ready", bus.req_ready, 1);
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [4:0] addr, input logic [3:0] data,
                        input logic [4:0] len, input int stall, input logic bad_rb);
    int         exp_lat, lat;
    logic [3:0] exp_data, got_data;
    logic       exp_err, got_err;
    logic [4:0] exp_wr [$];
    logic [4:0] exp_rd [$];
    exp_data = 4'h0;
    exp_err  = 1'b0;
    case (op)
      OP_LOAD: begin
        exp_lat  = 3;
        exp_data = model[addr];
        exp_rd.push_back(addr);
      end
      OP_STORE: begin
        exp_lat = STORE_LAT;
        exp_err = VERIFY && bad_rb;
        exp_wr.push_back(addr);
        if (VERIFY) exp_rd.push_back(addr);
      end
      OP_FILL: begin
        exp_lat = int'(len) + 2;
        for (int i = 0; i <= int'(len); i++) exp_wr.push_back(5'(int'(addr) + i));
      end
      default: begin
        exp_lat = 1;
        exp_err = 1'b1;
      end
    endcase
    wr_log.delete();
    wd_log.delete();
    rd_log.delete();
    corrupt = bad_rb;
    send(op, addr, data, len);
    get_rsp(exp_lat, exp_data, exp_err, stall, lat, got_data, got_err);
    corrupt = 1'b0;
    chk("write_count", wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      chk("write_addr", wr_log[i], exp_wr[i]);
      chk("write_data", wd_log[i], data);
    end
    chk("read_count", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) chk("read_addr", rd_log[i], exp_rd[i]);
    foreach (exp_wr[i]) model[exp_wr[i]] = data;
    $display("txn op=%0d addr=%0d data=%h len=%0d stall=%0d -> rsp_data=%h rsp_err=%0b latency=%0d",
             op, addr, data, len, stall, got_data, got_err, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [3:0] gd;
    logic       ge;
    int         r;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = 5'd0;
    bus.req_data  = 4'd0;
    bus.req_len   = 5'd0;
    bus.rsp_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_strobes", {mem_read, mem_write}, 0);
    chk("reset_addrs", {mem_read_address, mem_write_address}, 0);
    chk("reset_wdata", mem_data_to_write, 0);

    do_txn(OP_STORE, 5'd5, 4'hA, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd5, 4'h0, 5'd0, 0, 1'b0);

    do_txn(OP_STORE, 5'd2, 4'h5, 5'd0, 1, 1'b0);
    do_txn(OP_FILL, 5'd30, 4'h7, 5'd3, 0, 1'b0);
    do_txn(OP_LOAD, 5'd30, 4'h0, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd31, 4'h0, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd0, 4'h0, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd1, 4'h0, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd2, 4'h0, 5'd0, 0, 1'b0);

    do_txn(OP_RSVD, 5'd9, 4'h3, 5'd4, 2, 1'b0);

    // LOAD held under backpressure while a STORE waits behind it.
    send(OP_LOAD, 5'd30, 4'h0, 5'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_STORE;
    bus.req_addr  = 5'd12;
    bus.req_data  = 4'hC;
    bus.req_len   = 5'd0;
    get_rsp(3, model[30], 1'b0, 5, lat, gd, ge);
    $display("txn op=0 addr=30 queued-store -> rsp_data=%h rsp_err=%0b latency=%0d", gd, ge, lat);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    get_rsp(STORE_LAT, 4'h0, 1'b0, 0, lat, gd, ge);
    model[12] = 4'hC;
    $display("txn op=1 addr=12 data=c (queued) -> rsp_data=%h rsp_err=%0b latency=%0d", gd, ge, lat);
    do_txn(OP_LOAD, 5'd12, 4'h0, 5'd0, 0, 1'b0);

    // Reset sampled at the edge ending the first FILL write cycle.
    wr_log.delete();
    send(OP_FILL, 5'd0, 4'h3, 5'd7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model[0] = 4'h3;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.rsp_valid, 0);
      chk("abort_req_ready", bus.req_ready, 1);
    end
    chk("abort_write_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("abort_write_addr", wr_log[0], 0);
    $display("txn op=2 addr=0 len=7 aborted by reset -> writes=%0d", wr_log.size());
    do_txn(OP_LOAD, 5'd1, 4'h0, 5'd0, 0, 1'b0);
    do_txn(OP_LOAD, 5'd0, 4'h0, 5'd0, 0, 1'b0);

    do_txn(OP_STORE, 5'd9, 4'hF, 5'd0, 0, 1'b1);
    do_txn(OP_LOAD, 5'd9, 4'h0, 5'd0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      do_txn((r < 4) ? OP_LOAD : (r < 7) ? OP_STORE : (r < 9) ? OP_FILL : OP_RSVD,
             5'($urandom), 4'($urandom), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), 1'b0);
    end

    chk("read_write_exclusive", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
